// File: rtl/fp_pkg.sv
// Shared widths, state encoding and limit constants for the sign-magnitude to
// 8-bit float normalizer.
package fp_pkg;

  localparam int unsigned IN_W  = 13;
  localparam int unsigned EXP_W = 3;
  localparam int unsigned SIG_W = 4;
  localparam int unsigned MAG_W = IN_W - 1;

  localparam logic [EXP_W-1:0] EXP_MAX   = 3'd7;
  localparam logic [SIG_W-1:0] SIG_MAX   = 4'b1111;
  localparam logic [SIG_W-1:0] SIG_CARRY = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fp_round_unit.sv
// Combinational rounding of the normalized significand, with carry into the
// exponent and saturation. FP_ROUND_EN selects round-half-up; otherwise truncate.
module fp_round_unit
  import fp_pkg::*;
(
  input  logic [SIG_W-1:0] f0,
  input  logic             r,
  input  logic [EXP_W-1:0] exp_in,
  input  logic             sat,
  output logic [EXP_W-1:0] exp_c,
  output logic [SIG_W-1:0] sig_c
);

`ifdef FP_ROUND_EN
  logic [SIG_W:0] sum;

  assign sum = {1'b0, f0} + {{SIG_W{1'b0}}, r};

  always_comb begin
    exp_c = exp_in;
    sig_c = sum[SIG_W-1:0];
    // A carry out of the significand renormalizes to 1000 one exponent up.
    if (sum[SIG_W]) begin
      if (exp_in == EXP_MAX) begin
        exp_c = EXP_MAX;
        sig_c = SIG_MAX;
      end else begin
        exp_c = exp_in + EXP_W'(1);
        sig_c = SIG_CARRY;
      end
    end
    if (sat) begin
      exp_c = EXP_MAX;
      sig_c = SIG_MAX;
    end
  end
`else
  logic unused_r;

  assign unused_r = r;

  always_comb begin
    exp_c = exp_in;
    sig_c = f0;
    if (sat) begin
      exp_c = EXP_MAX;
      sig_c = SIG_MAX;
    end
  end
`endif

endmodule

// File: rtl/fp_normalize_seq.sv
// Sequential normalizer: one leading-zero shift per clock, then a rounding cycle,
// result held under valid/ready backpressure. Optional macro: FP_ROUND_EN.
module fp_normalize_seq
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_signmag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [SIG_W-1:0] out_sig
);

  state_t           state_q, state_d;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             sat_q, sat_d;
  logic             sign_q, sign_d;
  logic             ack_q, ack_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_sign_q, out_sign_d;
  logic [EXP_W-1:0] out_exp_q, out_exp_d;
  logic [SIG_W-1:0] out_sig_q, out_sig_d;

  logic [EXP_W-1:0] rnd_exp_c;
  logic [SIG_W-1:0] rnd_sig_c;

  fp_round_unit u_round (
    .f0     (mag_q[MAG_W-2 -: SIG_W]),
    .r      (mag_q[MAG_W-2-SIG_W]),
    .exp_in (exp_q),
    .sat    (sat_q),
    .exp_c  (rnd_exp_c),
    .sig_c  (rnd_sig_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      exp_q       <= '0;
      sat_q       <= 1'b0;
      sign_q      <= 1'b0;
      ack_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_sig_q   <= '0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      sat_q       <= sat_d;
      sign_q      <= sign_d;
      ack_q       <= ack_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_sig_q   <= out_sig_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    sat_d       = sat_q;
    sign_d      = sign_q;
    ack_d       = ack_q;
    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_sig_d   = out_sig_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d  = in_signmag[IN_W-1];
          mag_d   = in_signmag[MAG_W-1:0];
          exp_d   = EXP_MAX;
          sat_d   = in_signmag[MAG_W-1];
          state_d = in_signmag[MAG_W-1] ? ROUND : SHIFT;
        end
      end
      SHIFT: begin
        if (mag_q[MAG_W-2] || (exp_q == '0)) begin
          state_d = ROUND;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - EXP_W'(1);
        end
      end
      ROUND: begin
        out_sign_d = sign_q;
        out_exp_d  = rnd_exp_c;
        out_sig_d  = rnd_sig_c;
        state_d    = DONE;
      end
      DONE: begin
        // Raise valid, hold until taken, then spend one cycle before re-arming.
        if (ack_q) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end else if (out_valid_q) begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            ack_d       = 1'b1;
          end
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_sig   = out_sig_q;

endmodule

// File: tb/tb_fp_normalize_seq.sv
// Self-checking bench for fp_normalize_seq against an arithmetic reference model.
// Honours FP_ROUND_EN the same way the design does.
module tb_fp_normalize_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [12:0] in_signmag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [2:0]  out_exp;
  logic [3:0]  out_sig;

  int tests_run = 0;
  int tests_failed = 0;

  fp_normalize_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_signmag (in_signmag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_exp    (out_exp),
    .out_sig    (out_sig)
  );

  always #5 clk = ~clk;

  // Smallest exponent that fits the magnitude in 4 bits, then round the quotient.
  function automatic void model(input logic [12:0] w, output logic [7:0] res, output int lat);
    int mag, e0, fv;
    mag = int'(w[11:0]);
    if (mag >= 2048) begin
      res = {w[12], 3'd7, 4'hF};
      lat = 2;
      return;
    end
    e0 = 0;
    while (((mag >> e0) >= 16) && (e0 < 7)) e0++;
    lat = 10 - e0;
`ifdef FP_ROUND_EN
    fv = (e0 > 0) ? ((mag + (1 << (e0 - 1))) >> e0) : mag;
    if (fv == 16) begin
      if (e0 == 7) fv = 15;
      else begin
        e0++;
        fv = 8;
      end
    end
`else
    fv = mag >> e0;
`endif
    res = {w[12], 3'(e0), 4'(fv)};
  endfunction

  // Handshake one word and wait for out_valid; lat = -1 on timeout.
  task automatic send(input logic [12:0] w, output logic [7:0] res, output int lat);
    int n;
    n = 0;
    lat = -1;
    res = '0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) return;
    in_valid = 1'b1;
    in_signmag = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_signmag = 13'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    res = {out_sign, out_exp, out_sig};
  endtask

  task automatic consume();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({out_valid, out_sign, out_exp, out_sig} !== 9'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got %b want 0", {out_valid, out_sign, out_exp, out_sig});
    end
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_ready got %b want 0", in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [12:0] vec [8] = '{13'h0019, 13'h1080, 13'h03E0, 13'h0FFF,
                            13'h0000, 13'h1000, 13'h0040, 13'h07FF};
    logic [7:0] got, exp_res;
    int lat, exp_lat;
    for (int i = 0; i < 8; i++) begin
      model(vec[i], exp_res, exp_lat);
      send(vec[i], got, lat);
      tests_run++;
      if (got !== exp_res) begin
        tests_failed++;
        $display("FAIL directed_result in=%h got %b want %b", vec[i], got, exp_res);
      end
      tests_run++;
      if (lat !== exp_lat) begin
        tests_failed++;
        $display("FAIL directed_latency in=%h got %0d want %0d", vec[i], lat, exp_lat);
      end
      tests_run++;
      if (in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL directed_busy_in_ready in=%h got %b want 0", vec[i], in_ready);
      end
      consume();
    end
  endtask

  task automatic test_random();
    logic [12:0] w;
    logic [7:0] got, exp_res;
    int lat, exp_lat;
    for (int i = 0; i < 60; i++) begin
      w = {1'($urandom), 12'($urandom_range(0, 4095) >> $urandom_range(0, 11))};
      model(w, exp_res, exp_lat);
      send(w, got, lat);
      tests_run++;
      if (got !== exp_res) begin
        tests_failed++;
        $display("FAIL random_result in=%h got %b want %b", w, got, exp_res);
      end
      tests_run++;
      if (lat !== exp_lat) begin
        tests_failed++;
        $display("FAIL random_latency in=%h got %0d want %0d", w, lat, exp_lat);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] got, exp_res;
    int lat, exp_lat;
    model(13'h1123, exp_res, exp_lat);
    out_ready = 1'b0;
    send(13'h1123, got, lat);
    tests_run++;
    if (got !== exp_res || lat !== exp_lat) begin
      tests_failed++;
      $display("FAIL bp_first got %b/%0d want %b/%0d", got, lat, exp_res, exp_lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({out_valid, in_ready, out_sign, out_exp, out_sig} !== {2'b10, exp_res}) begin
        tests_failed++;
        $display("FAIL bp_hold cycle %0d got %b want %b", i,
                 {out_valid, in_ready, out_sign, out_exp, out_sig}, {2'b10, exp_res});
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL bp_release got valid/ready %b want 00", {out_valid, in_ready});
    end
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL bp_rearm got valid/ready %b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got, exp_res;
    int lat, exp_lat, n;
    bit saw_valid;
    n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1;
    in_signmag = 13'h0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({out_valid, in_ready, out_sign, out_exp, out_sig} !== 10'd0) begin
      tests_failed++;
      $display("FAIL abort_outputs got %b want 0", {out_valid, in_ready, out_sign, out_exp, out_sig});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    tests_run++;
    if (saw_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_output got valid=%b want 0", saw_valid);
    end
    model(13'h0040, exp_res, exp_lat);
    send(13'h0040, got, lat);
    tests_run++;
    if (got !== exp_res || lat !== exp_lat) begin
      tests_failed++;
      $display("FAIL after_abort got %b/%0d want %b/%0d", got, lat, exp_res, exp_lat);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
